// File: rtl/ascon_perm_engine.sv
// Iterative Ascon permutation engine: one full round per clock, p^12 or p^6,
// with optional absorption of a 64-bit data block into x0 at load time.
module ascon_perm_engine (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             mode12_i,
    input  logic             en_xor_data_i,
    input  logic [63:0]      data_i,
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       round_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [4:0][63:0] x_q, x_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [4:0][63:0] round_s;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        logic [127:0] tmp;
        tmp = {x, x} >> n;
        return tmp[63:0];
    endfunction

    // ~r equals 15-r for a 4-bit counter, giving the {15-r, r} round constant.
    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                     input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        logic [4:0][63:0] o;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'h0, ~r, r};
        x3 = s[3];
        x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = x0 ^ (~x1 & x2);
        t1 = x1 ^ (~x2 & x3);
        t2 = x2 ^ (~x3 & x4);
        t3 = x3 ^ (~x4 & x0);
        t4 = x4 ^ (~x0 & x1);
        t1 = t1 ^ t0;
        t3 = t3 ^ t2;
        t0 = t0 ^ t4;
        t2 = ~t2;
        o[0] = t0 ^ ror64(t0, 32'd19) ^ ror64(t0, 32'd28);
        o[1] = t1 ^ ror64(t1, 32'd61) ^ ror64(t1, 32'd39);
        o[2] = t2 ^ ror64(t2, 32'd1)  ^ ror64(t2, 32'd6);
        o[3] = t3 ^ ror64(t3, 32'd10) ^ ror64(t3, 32'd17);
        o[4] = t4 ^ ror64(t4, 32'd7)  ^ ror64(t4, 32'd41);
        return o;
    endfunction

    assign round_s = ascon_round(x_q, rnd_q);

    // Next-state: load on accepted start, one round per cycle while running.
    always_comb begin
        fsm_d = fsm_q;
        x_d   = x_q;
        rnd_d = rnd_q;
        case (fsm_q)
            IDLE, DONE: begin
                if (start_i) begin
                    x_d = state_i;
                    if (en_xor_data_i) begin
                        x_d[0] = state_i[0] ^ data_i;
                    end else begin
                        x_d[0] = state_i[0];
                    end
                    rnd_d = mode12_i ? 4'd0 : 4'd6;
                    fsm_d = RUN;
                end else if (fsm_q == DONE) begin
                    fsm_d = IDLE;
                end else begin
                    fsm_d = fsm_q;
                end
            end
            RUN: begin
                x_d = round_s;
                if (rnd_q == 4'd11) begin
                    rnd_d = rnd_q;
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                    fsm_d = RUN;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State, datapath and round counter registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= IDLE;
            x_q   <= '0;
            rnd_q <= 4'd0;
        end else begin
            fsm_q <= fsm_d;
            x_q   <= x_d;
            rnd_q <= rnd_d;
        end
    end

    assign state_o = x_q;
    assign round_o = rnd_q;
    assign busy_o  = (fsm_q == RUN);
    assign done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine; expected states come from a
// table-driven S-box model pushed to a scoreboard queue at each start.
module tb_ascon_perm_engine;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode12;
    logic             en_xor;
    logic [63:0]      data;
    logic [4:0][63:0] st_in;
    logic [4:0][63:0] st_out;
    logic             busy;
    logic             done;
    logic [3:0]       rnd;

    int total = 0;
    int bad   = 0;
    logic [4:0]       sbox_tbl [32];
    logic [4:0][63:0] exp_q [$];

    ascon_perm_engine dut (
        .clock_i       (clk),
        .resetb_i      (rst_n),
        .start_i       (start),
        .mode12_i      (mode12),
        .en_xor_data_i (en_xor),
        .data_i        (data),
        .state_i       (st_in),
        .state_o       (st_out),
        .busy_o        (busy),
        .done_o        (done),
        .round_o       (rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] model_perm(input logic [4:0][63:0] s_in, input int nr);
        logic [4:0][63:0] s, t;
        logic [4:0] col, o;
        logic [7:0] c;
        s = s_in;
        t = '0;
        for (int r = 12 - nr; r < 12; r++) begin
            c = 8'((15 - r) * 16 + r);
            s[2][7:0] = s[2][7:0] ^ c;
            for (int i = 0; i < 64; i++) begin
                col = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
                o = sbox_tbl[col];
                t[0][i] = o[4]; t[1][i] = o[3]; t[2][i] = o[2]; t[3][i] = o[1]; t[4][i] = o[0];
            end
            s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
            s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
            s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
            s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
            s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        end
        return s;
    endfunction

    task automatic run_perm(input string nm, input logic [4:0][63:0] s, input logic [63:0] d,
                            input logic m12, input logic xe, input bit disturb);
        int nr, cyc, busy_cnt;
        bit seen;
        logic [4:0][63:0] ld, exp_s, held;
        nr = m12 ? 12 : 6;
        ld = s;
        if (xe) ld[0] = s[0] ^ d;
        exp_q.push_back(model_perm(ld, nr));
        @(negedge clk);
        start = 1'b1; mode12 = m12; en_xor = xe; data = d; st_in = s;
        busy_cnt = 0;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (disturb && cyc == 4);
            st_in = ~s;
            if (busy === 1'b1) busy_cnt++;
            if (cyc <= nr) begin
                total++;
                if (rnd !== 4'(12 - nr + cyc - 1)) begin
                    bad++;
                    $display("FAIL %s round_o cyc %0d: got %0d want %0d", nm, cyc, rnd, 12 - nr + cyc - 1);
                end
            end
            if (done === 1'b1) seen = 1'b1;
        end
        exp_s = exp_q.pop_front();
        total++;
        if (!seen || cyc != nr + 1) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d) want %0d", nm, cyc, seen, nr + 1);
        end
        total++;
        if (busy_cnt != nr) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, nr);
        end
        total++;
        if (st_out !== exp_s) begin
            bad++;
            $display("FAIL %s state: got %h want %h", nm, st_out, exp_s);
        end
        held = st_out;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || st_out !== held) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b state %h want done=0 busy=0 state %h",
                     nm, done, busy, st_out, exp_s);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (st_out !== '0 || busy !== 1'b0 || done !== 1'b0 || rnd !== 4'd0) begin
            bad++;
            $display("FAIL reset: state=%h busy=%b done=%b round=%0d want all zero", st_out, busy, done, rnd);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_p6_zero();
        run_perm("p6_zero", '0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_p12_init();
        logic [4:0][63:0] s;
        s[0] = 64'h80400C0600000000;
        s[1] = 64'h0001020304050607;
        s[2] = 64'h08090A0B0C0D0E0F;
        s[3] = 64'h0001020304050607;
        s[4] = 64'h08090A0B0C0D0E0F;
        run_perm("p12_init", s, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_absorb();
        logic [4:0][63:0] s;
        run_perm("absorb_p6", '0, 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        run_perm("absorb_p12", s, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        logic [4:0][63:0] s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        run_perm("start_in_run", s, 64'h0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [4:0][63:0] s1, s2, exp_s;
        int cyc, first;
        for (int i = 0; i < 5; i++) begin
            s1[i] = {$urandom, $urandom};
            s2[i] = {$urandom, $urandom};
        end
        exp_q.push_back(model_perm(s1, 12));
        @(negedge clk);
        start = 1'b1; mode12 = 1'b1; en_xor = 1'b0; st_in = s1;
        first = 0;
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                exp_s = exp_q.pop_front();
                total++;
                if (st_out !== exp_s) begin
                    bad++;
                    $display("FAIL b2b state: got %h want %h", st_out, exp_s);
                end
                if (first == 0) begin
                    first = cyc;
                    exp_q.push_back(model_perm(s2, 12));
                    st_in = s2;
                    @(negedge clk);
                    cyc++;
                    start = 1'b0;
                    total++;
                    if (busy !== 1'b1 || done !== 1'b0) begin
                        bad++;
                        $display("FAIL b2b restart: busy=%b done=%b want busy=1 done=0", busy, done);
                    end
                end else begin
                    total++;
                    if (cyc - first != 13) begin
                        bad++;
                        $display("FAIL b2b spacing: got %0d want 13", cyc - first);
                    end
                    break;
                end
            end
        end
        total++;
        if (first != 13 || cyc >= 60) begin
            bad++;
            $display("FAIL b2b timing: first done at %0d want 13, last cyc %0d", first, cyc);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(negedge clk);
        start = 1'b1; mode12 = 1'b1; en_xor = 1'b0;
        for (int i = 0; i < 5; i++) st_in[i] = {$urandom, $urandom} | 64'h1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (st_out !== '0 || busy !== 1'b0 || done !== 1'b0 || rnd !== 4'd0) begin
            bad++;
            $display("FAIL rst_mid_run: state=%h busy=%b done=%b round=%0d want all zero", st_out, busy, done, rnd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL rst_no_done: got %0d active cycles want 0", dones);
        end
        run_perm("after_reset", st_in, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        sbox_tbl = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                     5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                     5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                     5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        rst_n  = 1'b0;
        start  = 1'b0;
        mode12 = 1'b0;
        en_xor = 1'b0;
        data   = 64'h0;
        st_in  = '0;
        test_reset();
        test_p6_zero();
        test_p12_init();
        test_absorb();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_perm_engine.md
ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

Interface
REQ-001 Types: ascon_pack::type_state (5 x 64-bit words, index 0 = x0); one clock; reset asynchronous, active-low.
REQ-002 clock_i  in  1  rising-edge clock.
REQ-003 resetb_i  in  1  asynchronous active-low reset.
REQ-004 start_i  in  1  request one permutation; sampled on rising edge.
REQ-005 mode12_i  in  1  1 = 12 rounds (p^a), 0 = 6 rounds (p^b); sampled with start_i.
REQ-006 en_xor_data_i  in  1  1 = XOR data_i into x0 at load; sampled with start_i.
REQ-007 data_i  in  64  data block absorbed into x0.
REQ-008 state_i  in  type_state  state loaded at start.
REQ-009 state_o  out  type_state  registered permutation state; feeds the end-of-permutation XOR stage.
REQ-010 busy_o  out  1  high while rounds are in progress.
REQ-011 done_o  out  1  one-cycle pulse; state_o holds the final result.
REQ-012 round_o  out  4  current round index r, 0..11.

Function
REQ-013 FSM states: IDLE, RUN, DONE; busy_o = (RUN); done_o = (DONE), both decoded from registered state only.
REQ-014 IDLE or DONE with start_i=1: on the edge, state register <= state_i with x0 ^= data_i when en_xor_data_i=1; round counter <= 0 if mode12_i=1, else 6; FSM -> RUN.
REQ-015 IDLE with start_i=0: state register and counter hold; DONE with start_i=0 -> IDLE, state register holds.
REQ-016 RUN: each edge applies one full round with the current counter value r, then increments the counter; at r=11 the round is applied and FSM -> DONE, counter holds 11.
REQ-017 start_i during RUN is ignored; no queuing, no abort.
REQ-018 Round = constant addition, then substitution, then linear diffusion, on the registered state.
REQ-019 Constant addition: x2[7:0] ^= {4'(15-r), 4'(r)}; for r=0 the constant is 0xF0, for r=11 it is 0x4B.
REQ-020 Substitution: Ascon 5-bit S-box applied bit-sliced to all 64 columns, x0 = MSB of the column index.
REQ-021 Linear layer (ROR = rotate right): x0^=ROR19^ROR28; x1^=ROR61^ROR39; x2^=ROR1^ROR6; x3^=ROR10^ROR17; x4^=ROR7^ROR41; each rotation uses the pre-layer word.
REQ-022 Latency: start sampled at edge E -> done_o high in the cycle after edge E+12 (12 rounds) or E+6 (6 rounds); busy_o high for exactly 12 or 6 cycles.
REQ-023 Back-to-back: start_i=1 while done_o=1 is accepted; done_o falls and RUN begins with no idle cycle.
REQ-024 round_o shows the counter; in IDLE/DONE it holds its last value.
REQ-025 state_o remains stable from DONE until the next accepted start.

Reset
REQ-026 resetb_i=0 immediately forces FSM=IDLE, state register = all-zero, counter=0, busy_o=0, done_o=0, regardless of clock.
REQ-027 Reset asserted in RUN aborts the permutation; no done_o pulse follows release.
REQ-028 After release, the first rising edge with start_i=1 is accepted normally.

Verification
REQ-029 Zero state, mode12_i=0, en_xor_data_i=0, one start -> busy_o high 6 cycles, round_o 6..11, done_o single pulse, state_o matches software model of p^6 on zero.
REQ-030 state_i = {IV 0x80400C0600000000, K = 000102..0F, N = 000102..0F}, mode12_i=1 -> state_o equals Ascon v1.2 reference p^12 output; done_o 13 cycles after start sampled.
REQ-031 state_i zero, data_i=0x0123456789ABCDEF, en_xor_data_i=1, 6 rounds -> result equals model of p^6 applied to x0=0x0123456789ABCDEF, others 0.
REQ-032 start_i pulsed at round 3 of a 12-round run -> ignored; single done_o after 12 rounds; result unchanged vs undisturbed run.
REQ-033 start_i held high through done_o -> second permutation starts the cycle done_o is high; two done_o pulses exactly 13 cycles apart (12 rounds).
REQ-034 resetb_i dropped mid-RUN, between clock edges -> state_o=0, busy_o=0 at once; no done_o after release.
